dfi_maint_sched: RTL and testbench
==================================

// Module: dfi_maint_sched
// PURPOSE
//  Maintenance scheduler on the controller side of the DFI master port. Times periodic
//  REFRESH, DFI controller-initiated updates (ctrlupd) and PHY-initiated updates (phyupd).
//  Borrows the DFI command bus from the main command scheduler via a req/gnt handshake
//  while it issues REF commands and runs update handshakes.
// PARAMETERS
//  T_REFI        3120  refresh interval, aclk cycles (>=2)
//  T_RFC         88    REF-to-next-command wait, aclk cycles (>=1)
//  MAX_POSTPONE  8     max refreshes that may be pending (1..15)
//  T_CTRLUPD_INT 32768 cycles between ctrlupd attempts (>=2)
//  T_CTRLUPD_MIN 4     min dfi_ctrlupd_req high time (>=1)
//  T_CTRLUPD_MAX 16    max dfi_ctrlupd_req high time (>T_CTRLUPD_MIN)
// PORTS
//  aclk             in  1  single clock
//  aresetn          in  1  asynchronous active-low reset
//  init_done        in  1  dfi_init_complete, qualified; 0 holds block idle
//  maint_req        out 1  bus request to main scheduler
//  maint_urgent     out 1  pending == MAX_POSTPONE
//  maint_gnt        in  1  scheduler idle, all banks precharged, bus released
//  cmd_valid        out 1  block drives the DFI command mux this cycle
//  cmd_cs_n/ras_n/cas_n/we_n  out 1 each  command for the mux
//  dfi_ctrlupd_req  out 1  DFI ctrlupd request
//  dfi_ctrlupd_ack  in  1  DFI ctrlupd acknowledge
//  dfi_phyupd_req   in  1  DFI phyupd request
//  dfi_phyupd_ack   out 1  DFI phyupd acknowledge
//  ref_pending      out 4  pending refresh count
//  ref_overflow     out 1  sticky: tick arrived while pending == MAX_POSTPONE
// BEHAVIOUR
//  Reset: all outputs 0, except cmd_cs_n/ras_n/cas_n/we_n = 1 (deselect).
//   FSM=IDLE, counters reloaded.
//  init_done=0: synchronous clear to the reset state; ref_overflow is kept.
//   Applies also mid-operation; that clears any in-flight handshake.
//  Refresh timer counts T_REFI-1..0. At 0: tick, reload, pending+1.
//   A tick at MAX_POSTPONE leaves pending unchanged and sets ref_overflow.
//   A tick in the same cycle as a REF issue leaves pending unchanged.
//  Ctrlupd timer counts T_CTRLUPD_INT-1..0. At 0: sets ctrlupd_due and holds at 0
//   until the CTRLUPD state is exited.
//  phy_pend = dfi_phyupd_req, sampled. Dropping the request before service clears it.
//  maint_req = (pending!=0 | ctrlupd_due | phy_pend) in IDLE; held 1 in every
//   non-IDLE state except DONE.
//  Handshake: the scheduler raises maint_gnt and holds it until maint_req falls.
//   A mid-operation gnt drop is ignored.
//  FSM:
//   IDLE: when maint_req & maint_gnt, go to the first of PHYUPD, REF_ISSUE, CTRLUPD,
//    taken in that priority order.
//   REF_ISSUE (1 cycle): cmd_valid=1, cs_n=0, ras_n=0, cas_n=0, we_n=1; pending-1.
//    Then REF_WAIT.
//   REF_WAIT: T_RFC cycles, cmd_valid=1 with NOP (cs_n=1). Then REF_ISSUE if
//    pending!=0 (drains all refreshes in one grant), else CTRLUPD if ctrlupd_due,
//    else DONE.
//   CTRLUPD: dfi_ctrlupd_req=1 from the entry cycle.
//    No ack by cycle T_CTRLUPD_MIN: drop req, go DONE.
//    Ack seen: hold req to T_CTRLUPD_MAX cycles total, drop it, then wait for ack=0
//     before DONE.
//    Clears ctrlupd_due and reloads its timer.
//   PHYUPD: dfi_phyupd_ack=1 the cycle after entry, held while dfi_phyupd_req=1.
//    Ack falls the cycle after req falls; then REF_ISSUE if pending!=0, else DONE.
//   DONE (1 cycle): maint_req=0, cmd_valid=0. Then IDLE.
//  Timers keep running in all states. Commands during a grant come only from this block.
// TESTING (T_REFI=100, T_RFC=10, MAX_POSTPONE=3, T_CTRLUPD_INT=1000, MIN=4, MAX=16)
//  1 init_done=1, gnt tied to req -> one REF (cs/ras/cas/we=0001) every 100 cycles;
//    maint_req spans 1+10+1 cycles per REF.
//  2 gnt held 0 for 350 cycles -> pending=3, maint_urgent=1, ref_overflow=0;
//    then gnt=1 -> 3 REFs 11 cycles apart, pending=0, then DONE.
//  3 gnt held 0 past the 4th tick -> ref_overflow=1 and stays 1; pending stays 3.
//  4 ctrlupd due, PHY never acks -> ctrlupd_req high exactly 4 cycles.
//    PHY acks at cycle 2 -> req high 16 cycles; DONE only after ack=0.
//  5 phyupd_req raised during REF_WAIT with pending=0 -> after the REF completes, ack
//    asserts; ack falls 1 cycle after req falls.
//    phyupd_req pulses low before gnt -> no ack.
//  6 init_done drops in REF_WAIT -> next cycle FSM IDLE, cmd_valid=0, pending=0,
//    maint_req=0. aresetn low mid-CTRLUPD -> ctrlupd_req=0 immediately.

Source files
------------

// File: rtl/dfi_maint_sched_if.sv
// dfi_maint_sched_if: scheduler handshake, DFI command mux and DFI update signals of the maintenance block
interface dfi_maint_sched_if;
  logic maint_req;
  logic maint_urgent;
  logic maint_gnt;
  logic cmd_valid;
  logic cmd_cs_n;
  logic cmd_ras_n;
  logic cmd_cas_n;
  logic cmd_we_n;
  logic dfi_ctrlupd_req;
  logic dfi_ctrlupd_ack;
  logic dfi_phyupd_req;
  logic dfi_phyupd_ack;
  modport master (
    output maint_req, maint_urgent, cmd_valid, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n,
    output dfi_ctrlupd_req, dfi_phyupd_ack,
    input  maint_gnt, dfi_ctrlupd_ack, dfi_phyupd_req
  );
  modport slave (
    input  maint_req, maint_urgent, cmd_valid, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n,
    input  dfi_ctrlupd_req, dfi_phyupd_ack,
    output maint_gnt, dfi_ctrlupd_ack, dfi_phyupd_req
  );
endinterface

// File: rtl/dfi_maint_sched.sv
// dfi_maint_sched: refresh/ctrlupd/phyupd scheduler (aclk, aresetn, init_done, bus, ref_pending, ref_overflow)
module dfi_maint_sched #(
  parameter int T_REFI        = 3120,
  parameter int T_RFC         = 88,
  parameter int MAX_POSTPONE  = 8,
  parameter int T_CTRLUPD_INT = 32768,
  parameter int T_CTRLUPD_MIN = 4,
  parameter int T_CTRLUPD_MAX = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                init_done,
  dfi_maint_sched_if.master   bus,
  output logic [3:0]          ref_pending,
  output logic                ref_overflow
);
  typedef enum logic [2:0] {IDLE, REF_ISSUE, REF_WAIT, CTRLUPD, PHYUPD, DONE} state_t;
  localparam int CLIM = (T_RFC - 1 > T_CTRLUPD_MAX) ? T_RFC - 1 : T_CTRLUPD_MAX;
  localparam int CW = $clog2(CLIM + 1);
  localparam int RW = $clog2(T_REFI);
  localparam int UW = $clog2(T_CTRLUPD_INT);
  localparam logic [RW-1:0] R_TOP = RW'(T_REFI - 1);
  localparam logic [UW-1:0] U_TOP = UW'(T_CTRLUPD_INT - 1);
  localparam logic [CW-1:0] C_RFC = CW'(T_RFC - 1);
  localparam logic [CW-1:0] C_MIN = CW'(T_CTRLUPD_MIN - 1);
  localparam logic [CW-1:0] C_MAX = CW'(T_CTRLUPD_MAX);
  localparam logic [CW-1:0] C_LIM = CW'(CLIM);
  localparam logic [3:0]    P_MAX = 4'(MAX_POSTPONE);
  state_t state, nxt;
  logic [RW-1:0] ref_cnt;
  logic [UW-1:0] cu_cnt;
  logic [CW-1:0] cnt;
  logic acked, phy_pend, phy_ack;
  logic tick, issue, due, pend_nz, req_idle, cu_exit;
  assign tick     = ref_cnt == '0;
  assign issue    = state == REF_ISSUE;
  assign due      = cu_cnt == '0;
  assign pend_nz  = ref_pending != 4'd0;
  assign req_idle = pend_nz | due | phy_pend;
  assign cu_exit  = (state == CTRLUPD) && (nxt != CTRLUPD);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= init_done ? nxt : IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = !(req_idle && bus.maint_gnt) ? IDLE : phy_pend ? PHYUPD : pend_nz ? REF_ISSUE : CTRLUPD;
      REF_ISSUE: nxt = REF_WAIT;
      REF_WAIT:  nxt = (cnt != C_RFC) ? REF_WAIT : pend_nz ? REF_ISSUE : due ? CTRLUPD : DONE;
      // without any ack the request is abandoned after the minimum high time;
      // once acked it runs to the maximum and then waits for the ack to clear
      CTRLUPD:   nxt = ((!(acked || bus.dfi_ctrlupd_ack) && cnt == C_MIN) ||
                        (cnt >= C_MAX && !bus.dfi_ctrlupd_ack)) ? DONE : CTRLUPD;
      PHYUPD:    nxt = bus.dfi_phyupd_req ? PHYUPD : pend_nz ? REF_ISSUE : DONE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      ref_cnt     <= R_TOP;
      cu_cnt      <= U_TOP;
      cnt         <= '0;
      acked       <= 1'b0;
      phy_pend    <= 1'b0;
      phy_ack     <= 1'b0;
      ref_pending <= 4'd0;
    end else if (!init_done) begin
      ref_cnt     <= R_TOP;
      cu_cnt      <= U_TOP;
      cnt         <= '0;
      acked       <= 1'b0;
      phy_pend    <= 1'b0;
      phy_ack     <= 1'b0;
      ref_pending <= 4'd0;
    end else begin
      ref_cnt     <= tick ? R_TOP : ref_cnt - 1'b1;
      cu_cnt      <= cu_exit ? U_TOP : due ? cu_cnt : cu_cnt - 1'b1;
      cnt         <= (nxt != state) ? '0 : (cnt == C_LIM) ? cnt : cnt + 1'b1;
      acked       <= (state == CTRLUPD) && (nxt == CTRLUPD) && (acked || bus.dfi_ctrlupd_ack);
      phy_pend    <= bus.dfi_phyupd_req;
      phy_ack     <= (state == PHYUPD) && bus.dfi_phyupd_req;
      // a tick and an issue in the same cycle cancel out
      ref_pending <= (tick && !issue && ref_pending != P_MAX) ? ref_pending + 4'd1 :
                     (issue && !tick) ? ref_pending - 4'd1 : ref_pending;
    end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) ref_overflow <= 1'b0;
    else ref_overflow <= ref_overflow | (init_done && tick && ref_pending == P_MAX);
  always_comb begin
    bus.maint_req       = (state == IDLE) ? req_idle : (state != DONE);
    bus.maint_urgent    = ref_pending == P_MAX;
    bus.cmd_valid       = issue || (state == REF_WAIT);
    bus.cmd_cs_n        = !issue;
    bus.cmd_ras_n       = !issue;
    bus.cmd_cas_n       = !issue;
    bus.cmd_we_n        = 1'b1;
    bus.dfi_ctrlupd_req = (state == CTRLUPD) && (cnt < C_MAX);
    bus.dfi_phyupd_ack  = phy_ack;
  end
endmodule

// File: tb/tb_dfi_maint_sched.sv
// tb_dfi_maint_sched: directed bench with a REF-time scoreboard for dfi_maint_sched
module tb_dfi_maint_sched;
  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic init_done = 1'b0;
  logic [3:0] ref_pending;
  logic ref_overflow;
  logic gnt_tie = 1'b0;
  logic gnt_force = 1'b0;
  logic sb_on = 1'b0;
  int cyc = 0;
  int t0 = 0;
  int m = 0;
  int n = 0;
  int sb_t = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  dfi_maint_sched_if bus();
  dfi_maint_sched #(
    .T_REFI(100), .T_RFC(10), .MAX_POSTPONE(3),
    .T_CTRLUPD_INT(1000), .T_CTRLUPD_MIN(4), .T_CTRLUPD_MAX(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .init_done(init_done), .bus(bus),
    .ref_pending(ref_pending), .ref_overflow(ref_overflow)
  );
  assign bus.maint_gnt = gnt_tie ? bus.maint_req : gnt_force;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic restart();
    @(negedge aclk);
    init_done = 1'b0;
    @(negedge aclk);
    init_done = 1'b1;
    t0 = cyc;
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge aclk);
  endtask
  always @(negedge aclk)
    if (sb_on && bus.cmd_valid && !bus.cmd_cs_n) begin
      if (exp_q.size() != 0) sb_t = exp_q.pop_front();
      else sb_t = -1;
      chk("ref_time", cyc, sb_t);
      chk("ref_cmd", {bus.cmd_cs_n, bus.cmd_ras_n, bus.cmd_cas_n, bus.cmd_we_n}, 4'b0001);
    end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.dfi_ctrlupd_ack = 1'b0;
    bus.dfi_phyupd_req = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    chk("rst_req", bus.maint_req, 0);
    chk("rst_valid", bus.cmd_valid, 0);
    chk("rst_cmd", {bus.cmd_cs_n, bus.cmd_ras_n, bus.cmd_cas_n, bus.cmd_we_n}, 4'b1111);
    chk("rst_cu", bus.dfi_ctrlupd_req, 0);
    chk("rst_pack", bus.dfi_phyupd_ack, 0);
    chk("rst_pend", ref_pending, 0);
    chk("rst_ovf", ref_overflow, 0);
    chk("rst_urg", bus.maint_urgent, 0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    // refresh with gnt following req: REFs at t0+101, +201, +301
    sb_on = 1'b1;
    gnt_tie = 1'b1;
    restart();
    exp_q.push_back(t0 + 101);
    exp_q.push_back(t0 + 201);
    exp_q.push_back(t0 + 301);
    n = 0;
    while (!bus.maint_req && n < 150) begin @(negedge aclk); n++; end
    chk("req_rise", cyc, t0 + 100);
    n = 0;
    while (bus.maint_req && n < 50) begin n++; @(negedge aclk); end
    chk("req_len", n, 12);
    wait_cyc(t0 + 320);
    chk("q_empty1", exp_q.size(), 0);
    // postponed refreshes drained in one grant
    gnt_tie = 1'b0;
    restart();
    wait_cyc(t0 + 350);
    chk("pp_pend", ref_pending, 3);
    chk("pp_urg", bus.maint_urgent, 1);
    chk("pp_ovf", ref_overflow, 0);
    m = cyc;
    gnt_force = 1'b1;
    exp_q.push_back(m + 1);
    exp_q.push_back(m + 12);
    exp_q.push_back(m + 23);
    n = 0;
    while (bus.maint_req && n < 60) begin @(negedge aclk); n++; end
    chk("drain_done", cyc, m + 34);
    chk("drain_pend", ref_pending, 0);
    chk("drain_valid", bus.cmd_valid, 0);
    gnt_force = 1'b0;
    chk("q_empty2", exp_q.size(), 0);
    // overflow on the 4th tick, sticky across init_done clear
    restart();
    wait_cyc(t0 + 399);
    chk("ovf_before", ref_overflow, 0);
    chk("ovf_pend3", ref_pending, 3);
    @(negedge aclk);
    chk("ovf_set", ref_overflow, 1);
    chk("ovf_pend_hold", ref_pending, 3);
    restart();
    chk("ovf_kept", ref_overflow, 1);
    chk("ovf_pend_clr", ref_pending, 0);
    // ctrlupd without ack, then with ack at cycle 2
    sb_on = 1'b0;
    gnt_tie = 1'b1;
    restart();
    n = 0;
    while (!bus.dfi_ctrlupd_req && n < 1200) begin @(negedge aclk); n++; end
    chk("cu1_seen", bus.dfi_ctrlupd_req, 1);
    n = 0;
    while (bus.dfi_ctrlupd_req && n < 40) begin n++; @(negedge aclk); end
    chk("cu_noack_len", n, 4);
    n = 0;
    while (!bus.dfi_ctrlupd_req && n < 1200) begin @(negedge aclk); n++; end
    chk("cu2_seen", bus.dfi_ctrlupd_req, 1);
    n = 1;
    while (n < 40) begin
      @(negedge aclk);
      if (!bus.dfi_ctrlupd_req) break;
      n++;
      if (n == 2) bus.dfi_ctrlupd_ack = 1'b1;
    end
    chk("cu_ack_len", n, 16);
    chk("cu_hold1", bus.maint_req, 1);
    @(negedge aclk);
    chk("cu_hold2", bus.maint_req, 1);
    bus.dfi_ctrlupd_ack = 1'b0;
    @(negedge aclk);
    chk("cu_done", bus.maint_req, 0);
    // phyupd raised during REF_WAIT
    sb_on = 1'b1;
    restart();
    exp_q.push_back(t0 + 101);
    wait_cyc(t0 + 105);
    chk("nop_valid", bus.cmd_valid, 1);
    chk("nop_cs", bus.cmd_cs_n, 1);
    bus.dfi_phyupd_req = 1'b1;
    wait_cyc(t0 + 114);
    chk("pu_entry_ack", bus.dfi_phyupd_ack, 0);
    @(negedge aclk);
    chk("pu_ack", bus.dfi_phyupd_ack, 1);
    repeat (4) @(negedge aclk);
    chk("pu_ack_held", bus.dfi_phyupd_ack, 1);
    bus.dfi_phyupd_req = 1'b0;
    @(negedge aclk);
    chk("pu_ack_fall", bus.dfi_phyupd_ack, 0);
    chk("pu_done", bus.maint_req, 0);
    // phyupd request withdrawn before grant
    gnt_tie = 1'b0;
    wait_cyc(t0 + 122);
    bus.dfi_phyupd_req = 1'b1;
    wait_cyc(t0 + 125);
    bus.dfi_phyupd_req = 1'b0;
    wait_cyc(t0 + 128);
    gnt_force = 1'b1;
    repeat (8) begin
      @(negedge aclk);
      chk("pu_no_ack", bus.dfi_phyupd_ack, 0);
    end
    gnt_force = 1'b0;
    chk("q_empty3", exp_q.size(), 0);
    // init_done drop inside REF_WAIT
    restart();
    wait_cyc(t0 + 205);
    chk("id_pend2", ref_pending, 2);
    gnt_force = 1'b1;
    exp_q.push_back(t0 + 206);
    wait_cyc(t0 + 209);
    chk("id_wait_valid", bus.cmd_valid, 1);
    init_done = 1'b0;
    @(negedge aclk);
    chk("id_valid", bus.cmd_valid, 0);
    chk("id_pend", ref_pending, 0);
    chk("id_req", bus.maint_req, 0);
    gnt_force = 1'b0;
    chk("q_empty4", exp_q.size(), 0);
    // async reset inside CTRLUPD
    sb_on = 1'b0;
    gnt_tie = 1'b1;
    restart();
    n = 0;
    while (!bus.dfi_ctrlupd_req && n < 1200) begin @(negedge aclk); n++; end
    chk("cu3_seen", bus.dfi_ctrlupd_req, 1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("ar_cu", bus.dfi_ctrlupd_req, 0);
    chk("ar_req", bus.maint_req, 0);
    chk("ar_ovf", ref_overflow, 0);
    chk("ar_pend", ref_pending, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
